// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and frame scheduler feeding the board UART transmitter
module uart_tx_feeder #(
    parameter int BAUD_CNT_MAX = 5207,
    parameter int DEPTH        = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_en,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    // Ten bits on the line plus one bit of slack for the transmitter's
    // start-up latency, so a frame always finishes its stop bit before
    // the next tx_en.
    localparam int FRAME_CYCLES = 11 * BAUD_CNT_MAX;
    localparam int PTR_W        = $clog2(DEPTH);
    localparam int LVL_W        = PTR_W + 1;
    localparam int GAP_W        = $clog2(FRAME_CYCLES);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = '0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;

    // Frame scheduler state
    state_t           r_state;
    state_t           w_state_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [7:0]       r_tx_data;
    logic [7:0]       w_tx_data_nxt;
    logic             r_tx_en;
    logic             w_tx_en_nxt;

    // Handshake decode
    logic             w_not_full;
    logic             w_not_empty;
    logic             w_wr;
    logic             w_pop;
    logic             w_reject;

    assign w_not_full  = (r_level != LVL_FULL);
    assign w_not_empty = (r_level != LVL_ZERO);
    assign w_wr        = in_valid && w_not_full;
    assign w_reject    = in_valid && !w_not_full;

    assign in_ready    = w_not_full;
    assign tx_data     = r_tx_data;
    assign tx_en       = r_tx_en;
    assign busy        = (r_state == S_WAIT) || w_not_empty;
    assign fifo_level  = r_level;
    assign overflow    = r_overflow;

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointer advance on write and pop; natural wrap at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy up/down counter; a simultaneous write and pop leaves it unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= '0;
        end else begin
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow flag; a new rejected byte beats a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_reject) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Scheduler state, guard counter and transmitter-facing registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_gap     <= '0;
            r_tx_data <= 8'h00;
            r_tx_en   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap     <= w_gap_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_en   <= w_tx_en_nxt;
        end
    end

    // Next-state: pop and launch a frame from IDLE, then count out the guard time.
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_nxt     = r_gap;
        w_tx_data_nxt = r_tx_data;
        w_tx_en_nxt   = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_pop         = 1'b1;
                    w_tx_data_nxt = r_mem[r_rd_ptr];
                    w_tx_en_nxt   = 1'b1;
                    w_gap_nxt     = '0;
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                w_gap_nxt = r_gap + 1'b1;
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
